// File: rtl/sprite_renderer.sv
// sprite_renderer: parametrised sprite pixel generator.
// Scan position vs. sprite origin -> external sprite-ROM address -> palette
// lookup -> registered RGB and hit flag, two vga_clk of latency.
// The external ROM is synchronous with one cycle of read latency.
// Optional feature: define SPRITE_MIRROR_EN to add the mirror_x input,
// which flips the sprite horizontally.
module sprite_renderer #(
    parameter int unsigned SPRITE_W        = 32,
    parameter int unsigned SPRITE_H        = 32,
    parameter int unsigned IDX_BITS        = 2,
    parameter int unsigned NUM_FRAMES      = 4,
    parameter int unsigned FRAME_DIV       = 8,
    parameter int unsigned TRANSPARENT_IDX = 0,
    localparam int unsigned ADDR_W  = $clog2(SPRITE_W * SPRITE_H * NUM_FRAMES),
    localparam int unsigned FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic                vsync_pulse,
    input  logic [9:0]          SpriteX,
    input  logic [9:0]          SpriteY,
    input  logic                sprite_en,
    input  logic                anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic                mirror_x,
`endif
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_BITS-1:0] rom_q,
    input  logic                pal_we,
    input  logic [IDX_BITS-1:0] pal_idx,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                hit,
    output logic [FRAME_W-1:0]  cur_frame
);

    localparam int unsigned DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned PAL_N      = 2 ** IDX_BITS;
    localparam int unsigned FRAME_SIZE = SPRITE_W * SPRITE_H;

    logic [10:0]      draw_x_e;
    logic [10:0]      draw_y_e;
    logic [10:0]      sprite_x_e;
    logic [10:0]      sprite_y_e;
    logic [10:0]      rel_x;
    logic [10:0]      rel_y;
    logic [10:0]      rel_x_eff;
    logic             inside_c;

    logic             run;
    logic             inside_d;
    logic             blank_d;
    logic [DIV_W-1:0] div_cnt;
    logic [11:0]      palette [PAL_N];

    // Stage 0: bounds test and ROM address, all compares 11-bit so no wrap at column 1023
    always_comb begin
        draw_x_e    = {1'b0, DrawX};
        draw_y_e    = {1'b0, DrawY};
        sprite_x_e  = {1'b0, SpriteX};
        sprite_y_e  = {1'b0, SpriteY};
        rel_x       = draw_x_e - sprite_x_e;
        rel_y       = draw_y_e - sprite_y_e;
        rel_x_eff   = rel_x;
`ifdef SPRITE_MIRROR_EN
        if (mirror_x) begin
            rel_x_eff = 11'(SPRITE_W - 1) - rel_x;
        end
`endif
        inside_c    = sprite_en
                    & (draw_x_e >= sprite_x_e) & (draw_x_e < sprite_x_e + 11'(SPRITE_W))
                    & (draw_y_e >= sprite_y_e) & (draw_y_e < sprite_y_e + 11'(SPRITE_H));
        rom_address = '0;
        if (inside_c) begin
            rom_address = ADDR_W'(32'(cur_frame) * FRAME_SIZE
                                  + 32'(rel_y) * SPRITE_W
                                  + 32'(rel_x_eff));
        end
    end

    // Stage 1: align inside/blank with rom_q; run masks the first pixel after reset release
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            inside_d <= 1'b0;
            blank_d  <= 1'b0;
        end else begin
            run      <= 1'b1;
            inside_d <= inside_c & run;
            blank_d  <= blank;
        end
    end

    // Stage 2: palette lookup into the registered pixel outputs
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
            hit   <= 1'b0;
        end else if (blank_d && inside_d && (rom_q != IDX_BITS'(TRANSPARENT_IDX))) begin
            red   <= palette[rom_q][11:8];
            green <= palette[rom_q][7:4];
            blue  <= palette[rom_q][3:0];
            hit   <= 1'b1;
        end else begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
            hit   <= 1'b0;
        end
    end

    // Palette write port; a same-cycle lookup still sees the old entry
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(PAL_N); i++) begin
                palette[i] <= 12'h000;
            end
        end else if (pal_we) begin
            palette[pal_idx] <= pal_rgb;
        end
    end

    // Animation: advance the frame every FRAME_DIV enabled vsync pulses
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            cur_frame <= '0;
        end else if (vsync_pulse && anim_en) begin
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt <= '0;
                if (cur_frame == FRAME_W'(NUM_FRAMES - 1)) begin
                    cur_frame <= '0;
                end else begin
                    cur_frame <= cur_frame + FRAME_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer (default parameters: 32x32, 2-bit index, 4 frames, divide by 8).
module tb_sprite_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic        blank, vsync_pulse, sprite_en, anim_en, pal_we;
    logic [11:0] rom_address;
    logic [1:0]  rom_q, pal_idx;
    logic [11:0] pal_rgb;
    logic [3:0]  red, green, blue;
    logic        hit;
    logic [1:0]  cur_frame;
`ifdef SPRITE_MIRROR_EN
    logic        mirror_x;
`endif

    sprite_renderer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .vsync_pulse (vsync_pulse),
        .SpriteX     (SpriteX),
        .SpriteY     (SpriteY),
        .sprite_en   (sprite_en),
        .anim_en     (anim_en),
`ifdef SPRITE_MIRROR_EN
        .mirror_x    (mirror_x),
`endif
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_rgb     (pal_rgb),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hit         (hit),
        .cur_frame   (cur_frame)
    );

    always #5 vga_clk = ~vga_clk;

    int          total = 0;
    int          bad   = 0;
    int          rom_mode = 0;
    logic [1:0]  rom_const = 2'd0;
    logic [11:0] pal_m [4];
    int          n_pulses = 0;

    // ROM contents: a constant, or a scrambled function of the address
    function automatic logic [1:0] rom_fn(input int a);
        if (rom_mode == 0) return rom_const;
        return 2'(a ^ (a >> 5) ^ (a >> 9) ^ (a >> 2));
    endfunction

    // Synchronous sprite ROM, one cycle of latency
    always @(posedge vga_clk) rom_q <= rom_fn(int'(rom_address));

    function automatic int frame_m();
        return (n_pulses / 8) % 4;
    endfunction

    // Reference pixel: what the sprite should look like at (dx,dy)
    function automatic void model_pix(input int dx, input int dy, input int sx, input int sy,
                                      input bit en, input bit blk, input bit mir,
                                      output int addr, output bit h, output int rgb);
        bit in_s;
        int rx, ry;
        logic [1:0] idx;
        in_s = en && dx >= sx && dx < sx + 32 && dy >= sy && dy < sy + 32;
        rx   = dx - sx;
        ry   = dy - sy;
        if (mir) rx = 31 - rx;
        addr = in_s ? (frame_m() * 1024 + ry * 32 + rx) % 4096 : 0;
        idx  = rom_fn(addr);
        h    = blk && in_s && idx != 2'd0;
        rgb  = h ? int'(pal_m[idx]) : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_pix(input int dx, input int dy, input int sx, input int sy,
                           input bit en, input bit blk);
        DrawX = 10'(dx); DrawY = 10'(dy); SpriteX = 10'(sx); SpriteY = 10'(sy);
        sprite_en = en; blank = blk;
    endtask

    task automatic pal_write(input logic [1:0] i, input logic [11:0] v);
        pal_we = 1'b1; pal_idx = i; pal_rgb = v;
        pal_m[i] = v;
        tick();
        pal_we = 1'b0;
    endtask

    task automatic pulse(input bit en);
        vsync_pulse = 1'b1; anim_en = en;
        if (en) n_pulses++;
        tick();
        vsync_pulse = 1'b0;
    endtask

    typedef struct {
        int         dx, dy, sx, sy;
        bit         en, blk;
        logic [1:0] rc;
        bit         ehit;
        int         ergb;
        int         eaddr;
    } vec_t;

    vec_t vecs [10];

    int  e_addr, e_rgb, p_rgb;
    bit  e_h, p_h, mir;
    int  dx, dy, sx, sy;
    bit  en, blk;

    initial begin
        vecs[0] = '{100, 50, 100, 50, 1'b1, 1'b1, 2'd1, 1'b1, 'hF00, 0};
        vecs[1] = '{132, 50, 100, 50, 1'b1, 1'b1, 2'd1, 1'b0, 0,     0};
        vecs[2] = '{131, 81, 100, 50, 1'b1, 1'b1, 2'd2, 1'b1, 'h0F0, 1023};
        vecs[3] = '{105, 53, 100, 50, 1'b1, 1'b1, 2'd0, 1'b0, 0,     101};
        vecs[4] = '{105, 53, 100, 50, 1'b1, 1'b0, 2'd1, 1'b0, 0,     101};
        vecs[5] = '{105, 53, 100, 50, 1'b0, 1'b1, 2'd1, 1'b0, 0,     0};
        vecs[6] = '{2,   10, 1020, 10, 1'b1, 1'b1, 2'd1, 1'b0, 0,    0};
        vecs[7] = '{1023, 10, 1020, 10, 1'b1, 1'b1, 2'd3, 1'b1, 'h00F, 3};
        vecs[8] = '{99,  50, 100, 50, 1'b1, 1'b1, 2'd1, 1'b0, 0,     0};
        vecs[9] = '{100, 49, 100, 50, 1'b1, 1'b1, 2'd1, 1'b0, 0,     0};

        reset_n = 1'b0; vsync_pulse = 1'b0; anim_en = 1'b0; pal_we = 1'b0;
        pal_idx = 2'd0; pal_rgb = 12'h000;
`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b0;
`endif
        set_pix(0, 0, 100, 50, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pal_m[i] = 12'h000;
        tick(); tick();
        chk("reset_hit", int'(hit), 0);
        chk("reset_rgb", int'({red, green, blue}), 0);
        chk("reset_frame", int'(cur_frame), 0);
        reset_n = 1'b1;
        tick(); tick();

        // Directed pixel table
        pal_write(2'd1, 12'hF00);
        pal_write(2'd2, 12'h0F0);
        pal_write(2'd3, 12'h00F);
        foreach (vecs[i]) begin
            rom_mode  = 0;
            rom_const = vecs[i].rc;
            set_pix(vecs[i].dx, vecs[i].dy, vecs[i].sx, vecs[i].sy, vecs[i].en, vecs[i].blk);
            #1;
            chk($sformatf("vec%0d_addr", i), int'(rom_address), vecs[i].eaddr);
            tick(); tick();
            chk($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].ehit));
            chk($sformatf("vec%0d_rgb", i), int'({red, green, blue}), vecs[i].ergb);
        end

        // Animation sequence
        set_pix(0, 0, 100, 50, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) pulse(1'b1);
        chk("anim_7", int'(cur_frame), 0);
        pulse(1'b1);
        chk("anim_8", int'(cur_frame), 1);
        for (int i = 0; i < 8; i++) pulse(1'b1);
        chk("anim_16", int'(cur_frame), 2);
        set_pix(105, 53, 100, 50, 1'b1, 1'b0);
        #1;
        chk("addr_frame2", int'(rom_address), 2149);
        set_pix(0, 0, 100, 50, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) pulse(1'b1);
        chk("anim_32_wrap", int'(cur_frame), 0);
        for (int i = 0; i < 8; i++) pulse(1'b1);
        for (int i = 0; i < 10; i++) pulse(1'b0);
        chk("anim_hold", int'(cur_frame), 1);
        anim_en = 1'b0;

        // Randomized traffic against the reference model
        rom_mode = 1;
        p_h = 1'b0; p_rgb = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sx = $urandom_range(1000, 1023);
                dx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(990, 1023);
            end else begin
                sx = $urandom_range(90, 130);
                dx = $urandom_range(80, 170);
            end
            sy  = $urandom_range(40, 70);
            dy  = $urandom_range(30, 110);
            en  = ($urandom_range(0, 5) != 0);
            blk = ($urandom_range(0, 3) != 0);
            mir = 1'b0;
`ifdef SPRITE_MIRROR_EN
            mir = 1'($urandom_range(0, 1));
            mirror_x = mir;
`endif
            set_pix(dx, dy, sx, sy, en, blk);
            vsync_pulse = ($urandom_range(0, 15) == 0);
            anim_en     = ($urandom_range(0, 3) != 0);
            pal_we      = ($urandom_range(0, 7) == 0);
            pal_idx     = 2'($urandom_range(0, 3));
            pal_rgb     = 12'($urandom);
            if (pal_we) pal_m[pal_idx] = pal_rgb;
            model_pix(dx, dy, sx, sy, en, blk, mir, e_addr, e_h, e_rgb);
            if (vsync_pulse && anim_en) n_pulses++;
            #1;
            chk("rnd_addr", int'(rom_address), e_addr);
            tick();
            if (i > 0) begin
                chk("rnd_hit", int'(hit), int'(p_h));
                chk("rnd_rgb", int'({red, green, blue}), p_rgb);
            end
            chk("rnd_frame", int'(cur_frame), frame_m());
            p_h = e_h; p_rgb = e_rgb;
        end
        vsync_pulse = 1'b0; pal_we = 1'b0;
`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b0;
`endif

        // Reset asserted mid-line while a sprite pixel is being drawn
        rom_mode = 0; rom_const = 2'd1;
        set_pix(0, 0, 100, 50, 1'b0, 1'b0);
        while (frame_m() == 0) pulse(1'b1);
        pal_write(2'd1, 12'hF00);
        set_pix(100, 50, 100, 50, 1'b1, 1'b1);
        tick(); tick(); tick();
        chk("pre_reset_hit", int'(hit), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_hit", int'(hit), 0);
        chk("mid_reset_rgb", int'({red, green, blue}), 0);
        chk("mid_reset_frame", int'(cur_frame), 0);
        tick();
        reset_n = 1'b1;
        n_pulses = 0;
        for (int i = 0; i < 4; i++) pal_m[i] = 12'h000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset_hit%0d", i), int'(hit), (i >= 2) ? 1 : 0);
            chk($sformatf("post_reset_rgb%0d", i), int'({red, green, blue}), int'(pal_m[1]));
        end
        chk("post_reset_frame", int'(cur_frame), 0);

`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b1;
        set_pix(100, 50, 100, 50, 1'b1, 1'b1);
        #1;
        chk("mirror_addr", int'(rom_address), 31);
        mirror_x = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Parametrised successor to the fixed 32x32, 2-bit-index, single-frame bloon renderer. It handles any sprite size, index depth and animation frame count.
- Takes the current scan position and the sprite origin, generates the sprite-ROM address and looks the index up in a run-time-writable palette.
- Outputs registered RGB plus a hit flag, so the layer compositor can overlay tower, bloon and projectile sprites.
- The sprite ROM stays external: synchronous, 1-cycle read latency.

Parameters:
- SPRITE_W, 32: sprite width in pixels (power of two, at most 256).
- SPRITE_H, 32: sprite height in pixels (at most 256).
- IDX_BITS, 2: palette index width. The palette holds 2^IDX_BITS entries.
- NUM_FRAMES, 4: number of animation frames stored consecutively in the ROM (at least 1).
- FRAME_DIV, 8: number of vsync pulses per animation step (at least 1).
- TRANSPARENT_IDX, 0: palette index treated as see-through.

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  high = active video (same polarity as the existing renderers).
- vsync_pulse  in  1  one-cycle strobe at start of frame.
- SpriteX  in  10  sprite top-left column.
- SpriteY  in  10  sprite top-left row.
- sprite_en  in  1  sprite visible.
- anim_en  in  1  animation advance enable.
- rom_address  out  ADDR_W  ADDR_W = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES).
- rom_q  in  IDX_BITS  ROM data, valid 1 cycle after rom_address.
- pal_we  in  1  palette write strobe.
- pal_idx  in  IDX_BITS  palette write index.
- pal_rgb  in  12  {R,G,B} 4 bits each.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- hit  out  1  opaque sprite pixel present.
- cur_frame  out  $clog2(NUM_FRAMES) (minimum 1)  current animation frame.

Behaviour:
- Reset (async assert, sync-style release):
  - red, green, blue, hit = 0.
  - cur_frame = 0, frame divider = 0.
  - All palette entries = 12'h000.
  - Pipeline valid/inside flags = 0.
  - Reset mid-line: the first two output cycles after release are 0 regardless of inputs.
- Stage 0, combinational on inputs:
  - relX = DrawX - SpriteX and relY = DrawY - SpriteY, computed in 11 bits.
  - inside = sprite_en & (DrawX >= SpriteX) & (DrawX < SpriteX+SPRITE_W) & (DrawY >= SpriteY) & (DrawY < SpriteY+SPRITE_H).
  - Compares are 11-bit, so a sprite near column 1023 does not wrap to column 0.
  - rom_address = cur_frame*SPRITE_W*SPRITE_H + relY*SPRITE_W + relX, truncated to ADDR_W.
  - When not inside, rom_address = 0.
- Stage 1 register: captures inside and blank. rom_q arrives in the same cycle.
- Stage 2 output register (latency is exactly 2 vga_clk from DrawX/DrawY to red/green/blue/hit):
  - If blank_d is low: RGB = 0, hit = 0.
  - Else if inside_d and rom_q != TRANSPARENT_IDX: RGB = palette[rom_q], hit = 1.
  - Otherwise: RGB = 0, hit = 0.
- Palette:
  - pal_we writes palette[pal_idx] <= pal_rgb on the clock edge.
  - A lookup of the same index in that cycle returns the old value; the new value is visible from the next cycle.
  - Writes are accepted at any time, including during active video.
- Animation:
  - On vsync_pulse with anim_en = 1, the divider increments.
  - When the divider reaches FRAME_DIV-1 it clears to 0 and cur_frame increments, wrapping from NUM_FRAMES-1 to 0.
  - With anim_en = 0, the divider and cur_frame hold.
  - cur_frame changes only on vsync_pulse, so there is no mid-frame tearing.
  - With FRAME_DIV = 1, the frame advances every vsync.
  - With NUM_FRAMES = 1, cur_frame stays 0.
- Simultaneous events: vsync_pulse coinciding with active-video pixels is not expected. If it occurs, the address for that pixel uses the pre-increment frame.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- When defined:
  - Adds input mirror_x (1 bit), sampled every cycle.
  - While mirror_x = 1, the address uses (SPRITE_W-1-relX) in place of relX, giving a horizontally flipped sprite for left-facing path segments.
  - Latency is unchanged.
- When undefined: the port is absent and relX is always used directly.

Test Plan:
- Palette and latency check:
  - Setup: reset; write palette[1] = 12'hF00; sprite at (100,50); ROM model returns 1 everywhere.
  - Stimulus: DrawX = 100, DrawY = 50, blank = 1.
  - Expected: 2 cycles later red = F, green = 0, blue = 0, hit = 1.
  - Expected: DrawX = 132 gives hit = 0, RGB = 0.
- Transparency and blank:
  - ROM returns 0 (TRANSPARENT_IDX) -> hit = 0, RGB = 0 inside the sprite.
  - ROM returns 1 with blank = 0 -> RGB = 0.
- Address generation:
  - With NUM_FRAMES = 4, sprite 32x32, cur_frame = 2 and rel (5,3): rom_address = 2*1024 + 3*32 + 5 = 2149.
  - With sprite_en = 0: rom_address = 0 and hit = 0.
- Animation:
  - FRAME_DIV = 8, anim_en = 1: cur_frame = 1 after the 8th vsync_pulse, wraps to 0 after the 32nd.
  - Dropping anim_en holds cur_frame across 10 further pulses.
- Edge and reset:
  - Sprite at SpriteX = 1020: DrawX = 2 gives hit = 0, with no wrap.
  - reset_n asserted mid-line: outputs are 0 immediately, cur_frame = 0, and palette[1] reads 000 afterwards.
- Mirror (SPRITE_MIRROR_EN defined):
  - mirror_x = 1, rel (0,0), frame 0 -> rom_address = 31.
